// File: rtl/fir_pkg.sv
// Shared types and width helpers for the sequential low-pass FIR engine.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_DRAIN,
    ST_OUT
  } fir_state_e;

  localparam int DefaultTaps = 21;
  localparam int TapIdxWidth = $clog2(DefaultTaps);

  // Full-precision accumulator width: one product plus log2(taps) growth bits.
  function automatic int acc_width(input int data_w, input int coeff_w, input int taps);
    return data_w + coeff_w + $clog2(taps);
  endfunction

  function automatic int tap_idx_width(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate with clear and enable; result is held between updates.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int DataWidth  = 10,
  parameter int CoeffWidth = 16,
  parameter int AccWidth   = acc_width(10, 16, DefaultTaps)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [CoeffWidth-1:0] coeff,
  input  logic signed [DataWidth-1:0]  sample,
  output logic signed [AccWidth-1:0]   acc
);

  localparam int ProdWidth = DataWidth + CoeffWidth;

  logic signed [ProdWidth-1:0] prod_p1;

  function automatic logic signed [AccWidth-1:0] sext(input logic signed [ProdWidth-1:0] p);
    return AccWidth'(p);
  endfunction

  assign prod_p1 = ProdWidth'(coeff) * ProdWidth'(sample);

  // p1 -> acc: product folded into the running sum
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + sext(prod_p1);
    end
  end

endmodule

// File: rtl/fir_seq_lpf.sv
// Time-multiplexed FIR: one MAC per cycle over all taps, coefficients read from an external registered LUT.
module fir_seq_lpf
  import fir_pkg::*;
#(
  parameter int DataWidth  = 10,
  parameter int CoeffWidth = 16,
  parameter int Taps       = 21,
  parameter int AccWidth   = acc_width(DataWidth, CoeffWidth, Taps)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic signed [DataWidth-1:0]   in_data_i,
  output logic                          coeff_ren_o,
  output logic [$clog2(Taps)-1:0]       coeff_addr_o,
  input  logic signed [CoeffWidth-1:0]  coeff_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic signed [AccWidth-1:0]    out_data_o
);

  localparam int IdxW = $clog2(Taps);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Taps - 1);

  fir_state_e                  state;
  logic [IdxW-1:0]             tap;
  logic [IdxW-1:0]             tap_p1;
  logic                        vld_p1;
  logic                        accept;
  logic signed [DataWidth-1:0] dl [Taps];

  assign accept = (state == ST_IDLE) && in_valid_i;

  // p0: sample intake, dl[0] holds the newest sample
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < Taps; i++) dl[i] <= '0;
    end else if (accept) begin
      for (int i = Taps - 1; i > 0; i--) dl[i] <= dl[i-1];
      dl[0] <= in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= ST_IDLE;
      in_ready_o   <= 1'b1;
      out_valid_o  <= 1'b0;
      coeff_ren_o  <= 1'b0;
      coeff_addr_o <= '0;
      tap          <= '0;
      tap_p1       <= '0;
      vld_p1       <= 1'b0;
    end else begin
      // LUT answers one cycle after issue, so the tap index rides along
      vld_p1 <= coeff_ren_o;
      tap_p1 <= tap;
      case (state)
        ST_IDLE: begin
          if (in_valid_i) begin
            state        <= ST_MAC;
            in_ready_o   <= 1'b0;
            coeff_ren_o  <= 1'b1;
            coeff_addr_o <= LastIdx;
            tap          <= '0;
          end
        end
        ST_MAC: begin
          if (tap == LastIdx) begin
            state        <= ST_DRAIN;
            coeff_ren_o  <= 1'b0;
            coeff_addr_o <= '0;
          end else begin
            tap          <= tap + IdxW'(1);
            coeff_addr_o <= LastIdx - (tap + IdxW'(1));
          end
        end
        ST_DRAIN: begin
          state       <= ST_OUT;
          out_valid_o <= 1'b1;
        end
        ST_OUT: begin
          if (out_ready_i) begin
            state       <= ST_IDLE;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // p1: coefficient return meets the delayed tap sample
  fir_mac_unit #(
    .DataWidth (DataWidth),
    .CoeffWidth(CoeffWidth),
    .AccWidth  (AccWidth)
  ) u_mac (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clr   (accept),
    .en    (vld_p1),
    .coeff (coeff_data_i),
    .sample(dl[tap_p1]),
    .acc   (out_data_o)
  );

endmodule

// File: tb/tb_fir_seq_lpf.sv
// Scoreboard bench for fir_seq_lpf with a behavioural coefficient LUT and golden convolution model.
module tb_fir_seq_lpf;

  localparam int DW = 10;
  localparam int CW = 16;
  localparam int NT = 21;
  localparam int AW = DW + CW + $clog2(NT);

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 coeff_ren;
  logic [4:0]           coeff_addr;
  logic signed [CW-1:0] coeff_q = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [AW-1:0] out_data;

  int h_tab [NT] = '{127, 242, 438, 700, 1018, 1371, 1732, 2065, 2335, 2511, 2572,
                     2511, 2335, 2065, 1732, 1371, 1018, 700, 438, 242, 127};

  longint hist [NT];
  longint sb [$];
  longint last_out = 0;
  int     n_tests = 0;
  int     n_fail = 0;
  int     bp_mode = 0;

  always #5 clk = ~clk;

  fir_seq_lpf dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .coeff_ren_o (coeff_ren),
    .coeff_addr_o(coeff_addr),
    .coeff_data_i(coeff_q),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data)
  );

  // h[k] lives at address NT-1-k
  always @(posedge clk) begin
    if (coeff_ren) coeff_q <= CW'(h_tab[NT-1-int'(coeff_addr)]);
  end

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_push(input longint x);
    longint acc;
    for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    acc = 0;
    for (int k = 0; k < NT; k++) acc += longint'(h_tab[k]) * hist[k];
    sb.push_back(acc);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NT; i++) hist[i] = 0;
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (rst_ni && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        chk("out", longint'(out_data), sb.pop_front());
        last_out = longint'(out_data);
      end
    end
  end

  task automatic send(input longint x);
    int w;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = DW'(x);
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (in_ready) model_push(x);
    else chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("drain", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic addr_probe(input longint x);
    int nren, lat, w;
    nren = 0;
    lat  = 0;
    w    = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = DW'(x);
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    model_push(x);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (coeff_ren) begin
        chk("addr", coeff_addr, NT - 1 - nren);
        nren++;
      end
      if (out_valid && lat == 0) lat = c;
    end
    chk("ren_cycles", nren, NT);
    chk("latency", lat, NT + 2);
  endtask

  initial begin
    longint held;
    int w;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_ren", coeff_ren, 0);
    chk("rst_addr", coeff_addr, 0);

    // impulse response, first sample also probes the address sequence
    addr_probe(1);
    for (int i = 0; i < NT - 1; i++) send(0);
    wait_drain();
    chk("impulse_last", last_out, 127);

    for (int i = 0; i < NT; i++) send(1);
    wait_drain();
    chk("dc_pos", last_out, 27650);
    for (int i = 0; i < NT; i++) send(-512);
    wait_drain();
    chk("dc_neg", last_out, -14156800);

    // backpressure: output held, pending sample not consumed
    @(negedge clk);
    bp_mode = 1;
    send(55);
    w = 0;
    while (!out_valid && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("bp_valid_seen", out_valid, 1);
    held = longint'(out_data);
    chk("bp_data", held, sb[0]);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = DW'(-77);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", longint'(out_data), held);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    bp_mode = 0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_ready", in_ready, 1);
    model_push(-77);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();

    // reset in the middle of MAC
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = DW'(100);
    @(negedge clk);
    chk("mr_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_ni = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_out_data", out_data, 0);
    chk("mr_ren", coeff_ren, 0);
    chk("mr_addr", coeff_addr, 0);
    chk("mr_in_ready", in_ready, 1);
    model_clear();
    @(posedge clk); #1 rst_ni = 1'b1;
    w = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) w++;
    end
    chk("mr_no_output", w, 0);
    send(1);
    wait_drain();
    chk("mr_impulse_first", last_out, 127);
    for (int i = 0; i < NT - 1; i++) send(0);
    wait_drain();

    // random stream under random backpressure
    @(negedge clk);
    bp_mode = 2;
    for (int i = 0; i < 40; i++) send(longint'($urandom_range(0, 1023)) - 512);
    @(negedge clk);
    bp_mode = 0;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_seq_lpf.md
# fir_seq_lpf

Time-multiplexed FIR engine that pulls coefficients from a registered coefficient LUT (`coeffLUT_lpf`-style responder: `ren`/`addr` in, data out one cycle later). For each accepted input sample it performs one multiply-accumulate per cycle over all taps and emits one filtered output sample. It sits between the ADC/decimation input stream and the downstream compression stage, and is the initiator/reader side of the coefficient LUT interface.

## Interface
Parameters:
- `DataWidth`, 10, signed input sample width
- `CoeffWidth`, 16, signed coefficient width (LUT data width)
- `Taps`, 21, number of filter taps; LUT depth
- `AccWidth`, `DataWidth+CoeffWidth+$clog2(Taps)`, accumulator/output width (derived, not overridden)

Ports:
- `clk_i` in 1: single clock
- `rst_ni` in 1: reset, synchronous, active-low
- `in_valid_i` in 1: input sample valid
- `in_ready_o` out 1: block can accept a sample
- `in_data_i` in DataWidth: signed input sample
- `coeff_ren_o` out 1: LUT read enable
- `coeff_addr_o` out $clog2(Taps): LUT address
- `coeff_data_i` in CoeffWidth: LUT data, valid one cycle after address issue
- `out_valid_o` out 1: filtered sample valid
- `out_ready_i` in 1: downstream accepts output
- `out_data_o` out AccWidth: signed filtered sample, full precision

## Operation
- Computes y[n] = sum over k=0..Taps-1 of h[k]·x[n-k]; h[k] is stored at LUT address `Taps-1-k` (first coefficient at highest address).
- Delay line: `Taps` registers, `dl[0]` newest. On input handshake, shift in `in_data_i` at `dl[0]`, drop `dl[Taps-1]`. Reset value all zero.
- FSM states: IDLE, MAC, DRAIN, OUT.
  - IDLE: `in_ready_o`=1. On `in_valid_i`: shift delay line, clear accumulator, tap counter k=0, go MAC.
  - MAC: `coeff_ren_o`=1, `coeff_addr_o`=Taps-1-k; k increments each cycle. After issuing k=Taps-1 go DRAIN.
  - DRAIN: one cycle absorbing the last LUT return; then go OUT.
  - OUT: `out_valid_o`=1, `out_data_o`=accumulator held stable. On `out_ready_i` go IDLE.
- Accumulate: each cycle the LUT returns h[k] (one cycle after issue), acc += signed(coeff_data_i)·signed(dl[k]) using a one-cycle-delayed k index. Product width DataWidth+CoeffWidth, sign-extended into AccWidth; no rounding, no saturation (AccWidth guarantees no overflow).
- `in_valid_i` outside IDLE is ignored; sample is not consumed (`in_ready_o`=0).
- `coeff_ren_o`=0 and `coeff_addr_o`=0 outside MAC.

## Timing
- Reset (sampled at `clk_i` edge with `rst_ni`=0): state IDLE, `in_ready_o`=1 after reset releases, `out_valid_o`=0, `out_data_o`=0, `coeff_ren_o`=0, `coeff_addr_o`=0, delay line and accumulator 0.
- Cycle 0 input handshake; cycles 1..Taps address issue; returns cycles 2..Taps+1; `out_valid_o` high from cycle Taps+2. Latency Taps+2 cycles; minimum sample period Taps+3 cycles (output handshake in cycle Taps+2, IDLE in Taps+3).
- `out_data_o`/`out_valid_o` registered and stable while `out_valid_o`=1 and `out_ready_i`=0.
- Reset asserted mid-MAC/OUT: everything returns to reset values next edge; partial result discarded; no output emitted.

## Structure
- Shared package `fir_pkg`: FSM state enum type, `AccWidth` derivation function, tap-index width localparam.
- One sub-module natural: `fir_mac_unit` (signed multiply, sign-extend, accumulate, clear/enable). Delay line and FSM stay in top.
- LUT instantiated outside this block (testbench instantiates the LUT with the default 21-tap table).

## Test plan
- Impulse: x=+1 then 20 zeros, `out_ready_i`=1 -> outputs 127, 242, 438, 700, 1018, 1371, 1732, 2065, 2335, 2511, 2572, then mirror down to 127.
- DC: 21+ samples of +1 -> 21st and later outputs = 27650; samples of -512 -> -14156800.
- Backpressure: hold `out_ready_i`=0 for 5 cycles in OUT -> `out_data_o` stable, `in_ready_o`=0, `in_valid_i` sample not consumed; release -> IDLE next cycle, pending sample then accepted.
- Address sequence: one sample -> `coeff_ren_o` high exactly 21 cycles, addresses 20 down to 0, output valid at cycle 23.
- Reset mid-MAC at cycle 10 -> all outputs to reset values, no `out_valid_o`; next impulse reproduces impulse response from clean zeros.
- Random stream with random `out_ready_i` -> outputs match golden convolution model, bit-exact.
